// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access sequencer and the data memory.
//
// Handshake: the master raises mem_enable_o with mem_write_o/mem_addr_o/mem_data_o
// stable and holds all four unchanged until it samples mem_ack_i high on a rising
// edge; the slave pulses mem_ack_i (with mem_data_i valid for reads) in any cycle
// after enable is seen. The master drops mem_enable_o the cycle after the ack is
// sampled, or after it gives up waiting. An ack while enable is low is ignored.
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport master (
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer: turns single-cycle MemRead/MemWrite into an enable/ack
// transaction with a variable-latency data memory, stalls the pipeline while the
// access is outstanding, returns registered load data and aborts on timeout.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o,
  output logic [1:0]        state_dbg_o,
  dmem_access_ctrl_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              enable_q, enable_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              req;

  // A store wins over a load when both are asserted, so only MemWrite_i picks the op.
  assign req = MemRead_i | MemWrite_i;

  // Next-state and datapath: latch the request in IDLE, wait for ack or timeout in ACCESS.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    enable_d = 1'b0;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d   = addr_i;
          wdata_d  = wdata_i;
          write_d  = MemWrite_i;
          cnt_d    = '0;
          enable_d = 1'b1;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem.mem_ack_i) begin
          // An ack on the last allowed cycle still completes normally.
          if (!write_q) rdata_d = mem.mem_data_i;
          rvalid_d = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q >= CNT_LIMIT) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          enable_d = 1'b1;
        end
      end
      S_DONE: begin
        // The completing instruction is still in EX/MEM here; never retrigger.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Stall covers the request cycle and all of ACCESS, releasing in DONE so the
  // pipeline advances at the end of DONE; held low while reset is asserted.
  always_comb begin
    stall_o = 1'b0;
    if (!rst_i) begin
      stall_o = (state_q == S_ACCESS) || ((state_q == S_IDLE) && req);
    end
  end

  assign rdata_o          = rdata_q;
  assign rdata_valid_o    = rvalid_q;
  assign err_o            = err_q;
  assign state_dbg_o      = state_q;
  assign mem.mem_enable_o = enable_q;
  assign mem.mem_write_o  = write_q;
  assign mem.mem_addr_o   = addr_q;
  assign mem.mem_data_o   = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a table of single transactions plus
// hand-written sequences for reset, back-to-back and reset-during-access.
module tb_dmem_access_ctrl;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              MemRead_i, MemWrite_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              stall_o, rdata_valid_o, err_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        state_dbg_o;

  dmem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  dmem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .MemRead_i     (MemRead_i),
    .MemWrite_i    (MemWrite_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .err_o         (err_o),
    .state_dbg_o   (state_dbg_o),
    .mem           (mem_if)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_lat;    // ACCESS cycle carrying the ack, 0 = never
    logic [31:0] ack_data;
    logic        exp_write;
    logic        exp_rvalid;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  // ---------------- driver tasks ----------------
  // Presents a request, walks ACCESS cycle by cycle, and ends at the DONE sample
  // point with the request still held (as EX/MEM does until the pipeline moves).
  task automatic run_txn(input vec_t v);
    @(posedge clk); #1;
    MemRead_i  = v.rd;
    MemWrite_i = v.wr;
    addr_i     = v.addr;
    wdata_i    = v.wdata;
    mem_if.mem_ack_i = 1'b0;
    @(negedge clk);
    check1({v.name, " req stall"}, stall_o, 1'b1);
    check32({v.name, " req state"}, 32'(state_dbg_o), 32'(ST_IDLE));
    check1({v.name, " req enable"}, mem_if.mem_enable_o, 1'b0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(posedge clk); #1;
      mem_if.mem_ack_i  = (k == v.ack_lat);
      mem_if.mem_data_i = (k == v.ack_lat) ? v.ack_data : (32'h5A5A_0000 + 32'(k));
      @(negedge clk);
      check1({v.name, " acc enable"}, mem_if.mem_enable_o, 1'b1);
      check1({v.name, " acc stall"}, stall_o, 1'b1);
      check1({v.name, " acc write"}, mem_if.mem_write_o, v.exp_write);
      check32({v.name, " acc addr"}, mem_if.mem_addr_o, v.addr);
      check32({v.name, " acc wdata"}, mem_if.mem_data_o, v.wdata);
      check1({v.name, " acc rvalid"}, rdata_valid_o, 1'b0);
      if (k == v.ack_lat) break;
    end
    @(posedge clk); #1;
    mem_if.mem_ack_i  = 1'b0;
    mem_if.mem_data_i = 32'hFFFF_FFFF;
    @(negedge clk);
    check32({v.name, " done state"}, 32'(state_dbg_o), 32'(ST_DONE));
    check1({v.name, " done enable"}, mem_if.mem_enable_o, 1'b0);
    check1({v.name, " done stall"}, stall_o, 1'b0);
    check1({v.name, " done rvalid"}, rdata_valid_o, v.exp_rvalid);
    check1({v.name, " done err"}, err_o, v.exp_err);
    exp_q.push_back(v.exp_rdata);
    check32({v.name, " done rdata"}, rdata_o, exp_q.pop_front());
  endtask

  // Drops the request after DONE and drives a stray ack in IDLE, which must be ignored.
  task automatic idle_check(input string name, input logic [31:0] exp_rdata);
    @(posedge clk); #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
    mem_if.mem_ack_i  = 1'b1;
    mem_if.mem_data_i = 32'h7777_7777;
    @(negedge clk);
    check32({name, " idle state"}, 32'(state_dbg_o), 32'(ST_IDLE));
    check1({name, " idle stall"}, stall_o, 1'b0);
    check1({name, " idle enable"}, mem_if.mem_enable_o, 1'b0);
    check1({name, " idle rvalid"}, rdata_valid_o, 1'b0);
    check1({name, " idle err"}, err_o, 1'b0);
    check32({name, " idle rdata"}, rdata_o, exp_rdata);
    @(posedge clk); #1;
    mem_if.mem_ack_i = 1'b0;
    @(negedge clk);
    check32({name, " idle2 state"}, 32'(state_dbg_o), 32'(ST_IDLE));
    check1({name, " idle2 rvalid"}, rdata_valid_o, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check32({name, " state"}, 32'(state_dbg_o), 32'(ST_IDLE));
    check1({name, " stall"}, stall_o, 1'b0);
    check32({name, " rdata"}, rdata_o, 32'h0);
    check1({name, " rvalid"}, rdata_valid_o, 1'b0);
    check1({name, " err"}, err_o, 1'b0);
    check1({name, " enable"}, mem_if.mem_enable_o, 1'b0);
    check1({name, " write"}, mem_if.mem_write_o, 1'b0);
    check32({name, " addr"}, mem_if.mem_addr_o, 32'h0);
    check32({name, " wdata"}, mem_if.mem_data_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t b2b_ld, b2b_st, post_rst;

    //          name          rd    wr    addr          wdata         lat ack_data      wr    rv    err   rdata
    vecs[0] = '{"load_lat3",  1'b1, 1'b0, 32'h0000_0010, 32'h0,        3, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{"store_lat1", 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'hAAAA_5555, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{"load_tmo",   1'b1, 1'b0, 32'h0000_0030, 32'h1111_1111, 0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{"ack_at_lim", 1'b1, 1'b0, 32'h0000_0044, 32'h0,        4, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[4] = '{"rd_and_wr",  1'b1, 1'b1, 32'h0000_0050, 32'h0BAD_F00D, 2, 32'h9999_9999, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[5] = '{"store_tmo",  1'b0, 1'b1, 32'h0000_0058, 32'h5555_AAAA, 0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{"load_lat1",  1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        1, 32'h1357_9BDF, 1'b0, 1'b1, 1'b0, 32'h1357_9BDF};
    b2b_ld   = '{"b2b_load",  1'b1, 1'b0, 32'h0000_0100, 32'h0,        2, 32'h2468_ACE0, 1'b0, 1'b1, 1'b0, 32'h2468_ACE0};
    b2b_st   = '{"b2b_store", 1'b0, 1'b1, 32'h0000_0104, 32'hA5A5_0001, 1, 32'h0,        1'b1, 1'b1, 1'b0, 32'h2468_ACE0};
    post_rst = '{"post_rst",  1'b1, 1'b0, 32'h0000_0200, 32'h0,        1, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b0, 32'h0F0F_0F0F};

    // Reset with a request and a stray ack present: everything must read zero.
    rst        = 1'b1;
    MemRead_i  = 1'b1;
    MemWrite_i = 1'b0;
    addr_i     = 32'h0000_0ABC;
    wdata_i    = 32'h0000_0DEF;
    mem_if.mem_ack_i  = 1'b1;
    mem_if.mem_data_i = 32'hBBBB_BBBB;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst        = 1'b0;
    MemRead_i  = 1'b0;
    mem_if.mem_ack_i = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset_idle");

    // Table: one transaction per record, followed by an idle cycle check.
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i]);
      idle_check(vecs[i].name, vecs[i].exp_rdata);
    end

    // Back-to-back: load with MemRead held through DONE, store presented in the very next cycle.
    run_txn(b2b_ld);
    run_txn(b2b_st);
    idle_check("b2b", 32'h2468_ACE0);

    // Reset on the 2nd ACCESS cycle, then a late ack one cycle after the reset edge.
    @(posedge clk); #1;
    MemRead_i = 1'b1;
    addr_i    = 32'h0000_0060;
    wdata_i   = 32'h0000_0000;
    @(negedge clk);
    check1("rst_mid req stall", stall_o, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check1("rst_mid acc1 enable", mem_if.mem_enable_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check32("rst_mid acc2 state", 32'(state_dbg_o), 32'(ST_ACCESS));
    @(posedge clk); #1;
    rst       = 1'b0;
    MemRead_i = 1'b0;
    mem_if.mem_ack_i  = 1'b1;
    mem_if.mem_data_i = 32'hFFFF_0000;
    @(negedge clk);
    check_all_zero("rst_mid after_edge");
    @(posedge clk); #1;
    mem_if.mem_ack_i = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid stray_ack");

    // Normal operation resumes after the mid-access reset.
    run_txn(post_rst);
    idle_check("post_rst", 32'h0F0F_0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Multi-cycle data-memory sequencer in the MEM stage of the 5-stage RISC-V pipeline. Converts the single-cycle MemRead/MemWrite intent produced by the main decoder for LOAD/STORE into an enable/ack handshake with a variable-latency data memory. While an access is outstanding it holds a stall to the hazard/pipeline-register logic. It also returns registered load data, and aborts with an error flag when the memory never acknowledges.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum ACCESS cycles before abort (≥1)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- MemRead_i  in  1  load request from EX/MEM register
- MemWrite_i  in  1  store request from EX/MEM register
- addr_i  in  ADDR_W  ALU result (byte address)
- wdata_i  in  DATA_W  store data (rs2)
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- rdata_o  out  DATA_W  load data to MEM/WB
- rdata_valid_o  out  1  one-cycle pulse, access complete
- err_o  out  1  one-cycle pulse, access timed out
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_W  latched address
- mem_data_o  out  DATA_W  latched write data
- mem_data_i  in  DATA_W  read data, valid with ack
- mem_ack_i  in  1  memory completion

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - When MemRead_i|MemWrite_i, latch addr_i, wdata_i and op into mem_addr_o/mem_data_o/mem_write_o; clear timeout counter; go to ACCESS.
  - If both MemRead_i and MemWrite_i are high, treat the request as a write; the read is ignored.
- ACCESS:
  - mem_enable_o=1.
  - On mem_ack_i: capture mem_data_i into rdata_o (reads only; rdata_o is unchanged on writes) and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ack: set rdata_o=0, flag the error, go to DONE.
  - Ack in the same cycle as the timeout limit: ack wins, no error.
- DONE:
  - mem_enable_o=0.
  - rdata_valid_o=1, or err_o=1 if aborted; the two are mutually exclusive.
  - Requests on MemRead_i/MemWrite_i are ignored in DONE (still the completing instruction).
  - Unconditionally return to IDLE.
- stall_o is combinational: 1 in IDLE when a request is present, 1 throughout ACCESS, 0 in DONE. This lets the pipeline advance exactly at the end of DONE.
- mem_ack_i outside ACCESS is ignored.
- Counter width is $clog2(TIMEOUT+1) and saturates; it never wraps.
- rdata_o holds its value until the next completed read, abort or reset.

## Timing
- Request present in IDLE at cycle N: stall_o=1 at N, and state=ACCESS with mem_enable_o=1 from N+1.
- Ack sampled at cycle N+k (k≥1): DONE at N+k+1 with rdata_valid_o=1 and stall_o=0; IDLE at N+k+2.
- Total stall = k+1 cycles; minimum access (ack in first ACCESS cycle) = 2 stall cycles + 1 DONE cycle.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then DONE with err_o=1.
- Back-to-back memory instructions: the next request is recognised in the IDLE cycle directly after DONE; no extra bubble.
- Reset values (any time, including mid-ACCESS): state=IDLE; all outputs 0 (stall_o, rdata_o, rdata_valid_o, err_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o). mem_enable_o drops on the reset edge. A late ack after reset is ignored.
- mem_* outputs are registered and stable for the entire ACCESS state.

## Test plan
- Load, ack latency 3: MemRead_i=1, addr_i=0x10; ack with mem_data_i=0xDEADBEEF on the 3rd ACCESS cycle -> mem_enable_o high 3 cycles; stall_o high 4 cycles; DONE has rdata_valid_o=1 and rdata_o=0xDEADBEEF.
- Store, ack latency 1: MemWrite_i=1, addr_i=0x20, wdata_i=0x12345678 -> mem_write_o=1, mem_addr_o=0x20, mem_data_o=0x12345678 for 1 cycle; rdata_o unchanged; rdata_valid_o pulse.
- Timeout, TIMEOUT=4, no ack -> ACCESS lasts exactly 4 cycles; err_o=1 in DONE; rdata_valid_o=0; rdata_o=0; stall_o released in DONE.
- Back-to-back: load, then store presented in the cycle after DONE -> second ACCESS starts 1 cycle after returning to IDLE; no request lost or duplicated; MemRead held through DONE does not retrigger.
- Reset mid-access: rst_i=1 on the 2nd ACCESS cycle, then ack one cycle later -> all outputs 0 after the edge; the stray ack produces no rdata_valid_o.
- Simultaneous MemRead_i=MemWrite_i=1 -> write performed (mem_write_o=1). Ack coinciding with the timeout limit -> rdata_valid_o=1, err_o=0.
